// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (fetch/data) arbiter onto a single-ported RAM with per-access timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise the data port has fixed priority.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  ARB_Clk,
  input  logic                  ARB_Reset,
  input  logic                  ARB_I_Req,
  input  logic                  ARB_D_Req,
  input  logic [ADDR_WIDTH-1:0] ARB_I_Address,
  input  logic [ADDR_WIDTH-1:0] ARB_D_Address,
  input  logic                  ARB_D_Write,
  input  logic [31:0]           ARB_D_Data_In,
  output logic                  ARB_I_Done,
  output logic                  ARB_D_Done,
  output logic [31:0]           ARB_I_Data_Out,
  output logic [31:0]           ARB_D_Data_Out,
  output logic                  ARB_Error,
  output logic                  ARB_RAM_Read_Ready,
  output logic                  ARB_RAM_Write_Valid,
  output logic [ADDR_WIDTH-1:0] ARB_RAM_Address,
  output logic [31:0]           ARB_RAM_Data_In,
  input  logic                  ARB_RAM_Read_Valid,
  input  logic                  ARB_RAM_Write_Ready,
  input  logic [31:0]           ARB_RAM_Data_Out
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] TO = 4'(TIMEOUT);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  wr_q, wr_d, sel_q, sel_d, err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pick_data, any_req;
  assign any_req = ARB_I_Req | ARB_D_Req;
`ifdef ARB_ROUND_ROBIN_EN
  logic i_next_q;
  assign pick_data = ARB_D_Req & ~(ARB_I_Req & i_next_q);
  // Fetch port goes next whenever the data port was just granted.
  always_ff @(posedge ARB_Clk) begin
    if (ARB_Reset) i_next_q <= 1'b1;
    else if (state_q == IDLE && any_req) i_next_q <= pick_data;
  end
`else
  assign pick_data = ARB_D_Req;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        state_d = ACCESS;
        sel_d   = pick_data;
        addr_d  = pick_data ? ARB_D_Address : ARB_I_Address;
        wr_d    = pick_data & ARB_D_Write;
        data_d  = pick_data ? ARB_D_Data_In : '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      ACCESS: if (wr_q ? ARB_RAM_Write_Ready : ARB_RAM_Read_Valid) begin
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == TO) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ARB_Clk) begin
    if (ARB_Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  logic acc, rsp, rd_ok;
  assign acc   = state_q == ACCESS;
  assign rsp   = state_q == RESP;
  assign rd_ok = rsp & ~wr_q & ~err_q;
  assign ARB_RAM_Read_Ready  = acc & ~wr_q;
  assign ARB_RAM_Write_Valid = acc & wr_q;
  assign ARB_RAM_Address     = acc ? addr_q : '0;
  assign ARB_RAM_Data_In     = acc ? data_q : '0;
  assign ARB_I_Done          = rsp & ~sel_q;
  assign ARB_D_Done          = rsp & sel_q;
  assign ARB_Error           = rsp & err_q;
  assign ARB_I_Data_Out      = (rd_ok & ~sel_q) ? ARB_RAM_Data_Out : '0;
  assign ARB_D_Data_Out      = (rd_ok & sel_q) ? ARB_RAM_Data_Out : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural RAM with 1-cycle read latency.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write;
  logic [9:0]  i_addr, d_addr;
  logic [31:0] d_din;
  logic        i_done, d_done, err;
  logic [31:0] i_dout, d_dout;
  logic        ram_rr, ram_wv, ram_rv, ram_wr;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        rv_en;
  logic [31:0] mem [0:1023];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  ram_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(15)) dut (
    .ARB_Clk(clk), .ARB_Reset(rst),
    .ARB_I_Req(i_req), .ARB_D_Req(d_req),
    .ARB_I_Address(i_addr), .ARB_D_Address(d_addr),
    .ARB_D_Write(d_write), .ARB_D_Data_In(d_din),
    .ARB_I_Done(i_done), .ARB_D_Done(d_done),
    .ARB_I_Data_Out(i_dout), .ARB_D_Data_Out(d_dout),
    .ARB_Error(err),
    .ARB_RAM_Read_Ready(ram_rr), .ARB_RAM_Write_Valid(ram_wv),
    .ARB_RAM_Address(ram_addr), .ARB_RAM_Data_In(ram_din),
    .ARB_RAM_Read_Valid(ram_rv), .ARB_RAM_Write_Ready(ram_wr),
    .ARB_RAM_Data_Out(ram_dout)
  );
  assign ram_rv = ram_rr & rv_en;
  assign ram_wr = ram_wv;
  always @(posedge clk) begin
    if (rst) mem[4] <= 32'h0000_0013;
    if (ram_wv) mem[ram_addr] <= ram_din;
    if (ram_rr) ram_dout <= mem[ram_addr];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  logic [3:0] seq;
  int early;
  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_write = 0; i_addr = '0; d_addr = '0; d_din = '0; rv_en = 1'b1;
    tick; tick;
    chk("rst_done", {30'd0, i_done, d_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ramctl", {30'd0, ram_rr, ram_wv}, 32'd0);
    chk("rst_addr", {22'd0, ram_addr}, 32'd0);
    rst = 1'b0;
    i_req = 1; i_addr = 10'h004;
    tick;
    chk("fetch_access_rr", {30'd0, ram_rr, ram_wv}, 32'd2);
    chk("fetch_access_addr", {22'd0, ram_addr}, 32'h4);
    chk("fetch_access_nodone", {30'd0, i_done, d_done}, 32'd0);
    i_addr = 10'h3ff;
    tick;
    chk("fetch_done", {30'd0, i_done, d_done}, 32'd2);
    chk("fetch_data", i_dout, 32'h0000_0013);
    chk("fetch_err", {31'd0, err}, 32'd0);
    chk("fetch_ddata", d_dout, 32'd0);
    i_req = 0;
    tick;
    chk("fetch_after", {30'd0, i_done, d_done}, 32'd0);
    chk("fetch_after_data", i_dout, 32'd0);
    d_req = 1; d_write = 1; d_addr = 10'h010; d_din = 32'hDEAD_BEEF;
    tick;
    d_din = 32'h0; d_addr = 10'h1; d_write = 0;
    chk("wr_ctl", {30'd0, ram_rr, ram_wv}, 32'd1);
    chk("wr_addr", {22'd0, ram_addr}, 32'h10);
    chk("wr_data", ram_din, 32'hDEAD_BEEF);
    tick;
    chk("wr_done", {30'd0, i_done, d_done}, 32'd1);
    chk("wr_dout", d_dout, 32'd0);
    d_req = 0;
    tick;
    d_req = 1; d_write = 0; d_addr = 10'h010;
    tick;
    chk("rd_ctl", {30'd0, ram_rr, ram_wv}, 32'd2);
    tick;
    chk("rd_done", {30'd0, i_done, d_done}, 32'd1);
    chk("rd_data", d_dout, 32'hDEAD_BEEF);
    d_req = 0;
    tick;
`ifdef ARB_ROUND_ROBIN_EN
    seq = 4'b1010;
`else
    seq = 4'b1111;
`endif
    i_req = 1; i_addr = 10'h004; d_req = 1; d_addr = 10'h010;
    for (int k = 0; k < 4; k++) begin
      tick; tick;
      chk($sformatf("arb%0d_done", k), {30'd0, i_done, d_done}, seq[k] ? 32'd1 : 32'd2);
      chk($sformatf("arb%0d_idata", k), i_dout, seq[k] ? 32'd0 : 32'h13);
      chk($sformatf("arb%0d_ddata", k), d_dout, seq[k] ? 32'hDEAD_BEEF : 32'd0);
      if (k == 3) begin i_req = 0; d_req = 0; end
      tick;
    end
    rv_en = 0; i_req = 1; i_addr = 10'h004;
    tick;
    early = 0;
    for (int k = 0; k < 14; k++) begin
      tick;
      if (i_done | d_done | err) early++;
    end
    chk("to_no_early_done", early, 32'd0);
    tick;
    chk("to_done", {30'd0, i_done, d_done}, 32'd2);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_data", i_dout, 32'd0);
    i_req = 0; rv_en = 1;
    tick;
    chk("to_idle_err", {31'd0, err}, 32'd0);
    chk("to_idle_ctl", {30'd0, ram_rr, ram_wv}, 32'd0);
    i_req = 1; i_addr = 10'h004;
    tick;
    chk("abort_access", {30'd0, ram_rr, ram_wv}, 32'd2);
    rst = 1;
    tick;
    rst = 0;
    chk("abort_nodone", {30'd0, i_done, d_done}, 32'd0);
    chk("abort_ctl", {30'd0, ram_rr, ram_wv}, 32'd0);
    d_req = 1; d_addr = 10'h010;
    tick;
`ifdef ARB_ROUND_ROBIN_EN
    seq = 4'b0000;
`else
    seq = 4'b0001;
`endif
    chk("post_rst_addr", {22'd0, ram_addr}, seq[0] ? 32'h10 : 32'h4);
    tick;
    chk("post_rst_done", {30'd0, i_done, d_done}, seq[0] ? 32'd1 : 32'd2);
    chk("post_rst_data", seq[0] ? d_dout : i_dout, seq[0] ? 32'hDEAD_BEEF : 32'h13);
    i_req = 0; d_req = 0;
    tick;
    chk("final_idle", {29'd0, i_done, d_done, err}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, max ACCESS wait cycles before error (4-bit counter, 1..15).
REQ-003 ARB_Clk  in  1  single clock; all state changes on rising edge.
REQ-004 ARB_Reset  in  1  synchronous, active-high reset.
REQ-005 ARB_I_Req / ARB_D_Req  in  1 each  fetch/data port request, held until that port's Done.
REQ-006 ARB_I_Address / ARB_D_Address  in  ADDR_WIDTH each  word address.
REQ-007 ARB_D_Write  in  1  data-port write (1) or read (0); fetch port is read-only.
REQ-008 ARB_D_Data_In  in  32  data-port write data.
REQ-009 ARB_I_Done / ARB_D_Done  out  1 each  one-cycle completion pulse.
REQ-010 ARB_I_Data_Out / ARB_D_Data_Out  out  32 each  read data, valid only while own Done=1, else 0.
REQ-011 ARB_Error  out  1  pulses with Done when the access timed out.
REQ-012 ARB_RAM_Read_Ready, ARB_RAM_Write_Valid  out  1 each  RAM controls.
REQ-013 ARB_RAM_Address  out  ADDR_WIDTH;  ARB_RAM_Data_In  out  32  RAM address/write data.
REQ-014 ARB_RAM_Read_Valid, ARB_RAM_Write_Ready  in  1 each;  ARB_RAM_Data_Out  in  32  RAM responses (RAM read data registered, 1-cycle latency).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-016 IDLE: if any Req=1, SHALL select winner (REQ-029), latch its address, write flag, write data and identity, go ACCESS; else stay IDLE.
REQ-017 ACCESS: SHALL drive RAM_Address/RAM_Data_In from latched values; RAM_Read_Ready = ~write, RAM_Write_Valid = write; all RAM controls 0 in other states.
REQ-018 ACCESS: go RESP at edge where (read and RAM_Read_Valid) or (write and RAM_Write_Ready); otherwise increment wait counter.
REQ-019 ACCESS: when wait counter reaches TIMEOUT, SHALL go RESP with error flag set.
REQ-020 RESP: SHALL pulse winner's Done for exactly one cycle, then go IDLE; loser Done stays 0.
REQ-021 RESP, read winner: winner's Data_Out = RAM_Data_Out (combinational); write or error: Data_Out = 0.
REQ-022 ARB_Error = 1 only in RESP with error flag set.
REQ-023 Latency with responsive RAM: Req seen in IDLE cycle N -> ACCESS N+1 -> Done N+2; one access per 3 cycles.
REQ-024 Requester SHALL deassert Req in the cycle after Done; Req still high in IDLE is a new request.
REQ-025 Request changes while not IDLE SHALL be ignored; latched values stay stable through ACCESS.
REQ-026 Address, data and write flag are used unmodified; no arithmetic on addresses.

Reset
REQ-027 On ARB_Reset=1 at an edge: state IDLE, wait counter 0, error flag 0, latched regs 0, priority pointer = fetch port next; all outputs 0 the following cycle.
REQ-028 Reset mid-ACCESS SHALL abort without Done; a RAM write sampled at that same edge may complete; requester re-requests.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN. Defined: on simultaneous requests, grant port not granted last; pointer updates on every grant. Undefined: fixed priority, data port always wins; no pointer register.

Verification
REQ-030 Reset, then I_Req=1, addr 0x004, RAM returns 0x00000013 -> I_Done at cycle 3, I_Data_Out=0x00000013, Error=0.
REQ-031 D_Req write addr 0x010 data 0xDEADBEEF, then D read 0x010 -> second D_Done with D_Data_Out=0xDEADBEEF.
REQ-032 I_Req and D_Req both held for 4 accesses -> RR_EN: grants D? no, I,D,I,D; undefined: D,D,D,D while D holds.
REQ-033 RAM_Read_Valid held 0 -> Done and Error together after 15 ACCESS cycles, Data_Out=0, then IDLE.
REQ-034 ARB_Reset asserted during ACCESS -> no Done, RAM controls 0 next cycle, next request served normally.
